// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame controller.
//   fft_state_e : controller FSM state encoding
//   MAX_AW      : widest supported address (1024 points)
//   bitrev()    : reverses the low w bits of v into the low w bits of the result
package fft_pkg;

  localparam int MAX_AW = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAPTURE   = 2'd1,
    ST_START     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } fft_state_e;

  function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] v, input int w);
    logic [MAX_AW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_AW; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_handshake_rx.sv
// Four-phase handshake receiver.
//   clk, rst    : clock, synchronous active-high reset
//   capture_en  : controller is in CAPTURE and may take samples
//   req_i       : source request
//   data_i      : source sample, valid while req_i is high
//   accept      : combinational, a sample is taken on this edge
//   ans_o       : one-cycle acknowledge, the cycle after accept
//   wr_data     : captured sample, valid while ans_o is high
module fft_handshake_rx #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture_en,
  input  logic          req_i,
  input  logic [DW-1:0] data_i,
  output logic          accept,
  output logic          ans_o,
  output logic [DW-1:0] wr_data
);

  logic          armed;
  logic          ans_p1;
  logic [DW-1:0] data_p1;

  // armed only re-sets once req_i has been seen low, so one request
  // held high across many cycles yields exactly one accept
  assign accept = capture_en & req_i & armed & ~ans_p1;

  // stage p0 -> p1: acknowledge and captured sample
  always_ff @(posedge clk) begin
    if (rst) begin
      armed   <= 1'b0;
      ans_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      ans_p1 <= accept;
      if (accept) begin
        armed   <= 1'b0;
        data_p1 <= data_i;
      end else if (!req_i) begin
        armed <= 1'b1;
      end
    end
  end

  assign ans_o   = ans_p1;
  assign wr_data = data_p1;

endmodule

// File: rtl/fft_frame_ctrl.sv
// FFT frame capture controller.
// Collects N_POINTS samples from a four-phase source into an external
// frame buffer (optionally in bit-reversed order), starts the FFT core,
// waits for completion and counts finished frames.
//   clk, rst          : clock, synchronous active-high reset
//   enable            : run request, frames captured back to back while high
//   req_i, data_i     : source request and sample
//   ans_o             : one-cycle acknowledge to source
//   wr_en/addr/data   : frame-buffer write port
//   fft_ready         : FFT core idle
//   fft_start         : one-cycle FFT start
//   fft_done          : one-cycle FFT completion
//   busy              : controller not idle
//   frame_cnt         : completed frames, wraps at 256
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int N_POINTS = 64,
  parameter int DW       = 16,
  parameter int BITREV   = 1,
  localparam int AW      = $clog2(N_POINTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          req_i,
  input  logic [DW-1:0] data_i,
  output logic          ans_o,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic          fft_ready,
  output logic          fft_start,
  input  logic          fft_done,
  output logic          busy,
  output logic [7:0]    frame_cnt
);

  fft_state_e    state, state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] addr_p0;
  logic [AW-1:0] addr_p1;
  logic          accept_p0;
  logic          last_p0;
  logic [7:0]    frame_cnt_q;

  fft_handshake_rx #(.DW(DW)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .capture_en (state == ST_CAPTURE),
    .req_i      (req_i),
    .data_i     (data_i),
    .accept     (accept_p0),
    .ans_o      (ans_o),
    .wr_data    (wr_data)
  );

  assign last_p0 = accept_p0 && (cnt == AW'(N_POINTS - 1));

  always_comb begin
    addr_p0 = cnt;
    if (BITREV != 0) addr_p0 = AW'(bitrev(MAX_AW'(cnt), AW));
  end

  always_comb begin
    state_nxt = state;
    fft_start = 1'b0;
    case (state)
      ST_IDLE:      if (enable) state_nxt = ST_CAPTURE;
      // enable is deliberately ignored here: a started frame always completes
      ST_CAPTURE:   if (last_p0) state_nxt = ST_START;
      ST_START: begin
        if (fft_ready) begin
          fft_start = ~rst;
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: if (fft_done) state_nxt = enable ? ST_CAPTURE : ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // stage p0 -> p1: control state and write address
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      addr_p1     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) cnt <= '0;
      else if (accept_p0)   cnt <= cnt + AW'(1);
      if (accept_p0) addr_p1 <= addr_p0;
      if (state == ST_WAIT_DONE && fft_done) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign wr_en     = ans_o;
  assign wr_addr   = addr_p1;
  assign busy      = (state != ST_IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
module tb_fft_frame_ctrl;

  localparam int NP = 8;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, enable, req_i, fft_ready, fft_done;
  logic [DW-1:0] data_i;
  logic          ans_o, wr_en, fft_start, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0]    frame_cnt;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.N_POINTS(NP), .DW(DW), .BITREV(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req_i     (req_i),
    .data_i    (data_i),
    .ans_o     (ans_o),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .fft_ready (fft_ready),
    .fft_start (fft_start),
    .fft_done  (fft_done),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int n_ans = 0;
  int n_start = 0;
  int last_wr_cyc = -1;
  int start_cyc = -1;
  int exp_ans = 0;
  int exp_start = 0;
  int idx = 0;
  int frames = 0;
  logic [AW+DW-1:0] got_q[$];
  logic [AW+DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model address: sample index with its AW bits mirrored.
  function automatic int rev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < AW; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  // One clock: observe mid-cycle, then step past the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (wr_en === 1'b1) begin
      got_q.push_back({wr_addr, wr_data});
      last_wr_cyc = cycle;
    end
    if (ans_o === 1'b1) n_ans++;
    if (fft_start === 1'b1) begin
      n_start++;
      start_cyc = cycle;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic expect_sample(input logic [DW-1:0] d);
    exp_q.push_back({AW'(rev(idx)), d});
    idx = (idx + 1) % NP;
    exp_ans++;
  endtask

  task automatic wait_ack(input string tag, input int a0, input logic [DW-1:0] d);
    for (int t = 0; t < 100 && n_ans == a0; t++) cyc();
    chk(tag, n_ans != a0, 1);
    if (n_ans != a0) expect_sample(d);
  endtask

  task automatic send(input logic [DW-1:0] d, input int hold, input int gap);
    int a0;
    a0 = n_ans;
    req_i  = 1'b1;
    data_i = d;
    wait_ack("handshake_ack", a0, d);
    repeat (hold) cyc();
    req_i  = 1'b0;
    data_i = DW'($urandom);
    repeat (1 + gap) cyc();
  endtask

  task automatic check_frame();
    chk("wr_count", got_q.size(), exp_q.size());
    chk("ans_count", n_ans, exp_ans);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk("wr_addr_data", got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic frame_end(input logic en_after);
    for (int t = 0; t < 100 && n_start <= exp_start; t++) cyc();
    exp_start++;
    chk("fft_start_count", n_start, exp_start);
    chk("wr_not_after_start", last_wr_cyc <= start_cyc, 1);
    fft_done = 1'b1;
    enable   = en_after;
    cyc();
    fft_done = 1'b0;
    frames++;
    cyc();
    chk("frame_cnt", frame_cnt, frames % 256);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; req_i = 1'b0; data_i = '0;
    fft_ready = 1'b1; fft_done = 1'b0;
    repeat (3) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_ans", ans_o, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_fft_start", fft_start, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    cyc();

    // Frame 1: data 1..8, randomized holds/gaps, spurious fft_done mid-frame.
    enable = 1'b1;
    for (int s = 0; s < NP; s++) begin
      send(DW'(s + 1), $urandom_range(0, 3), $urandom_range(0, 2));
      if (s == 3) begin
        fft_done = 1'b1;
        cyc();
        fft_done = 1'b0;
        cyc();
        chk("done_in_capture_ignored", frame_cnt, 0);
        chk("busy_capture", busy, 1);
      end
    end
    check_frame();
    frame_end(1'b1);

    // Frame 2: held request gives one accept; FFT core not ready at the end.
    send(16'h1234, 3, 0);
    for (int s = 1; s < NP - 1; s++) send(DW'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    fft_ready = 1'b0;
    send(DW'($urandom), 0, 0);
    check_frame();
    begin
      int a0;
      a0 = n_ans;
      req_i  = 1'b1;
      data_i = 16'hBEEF;
      repeat (10) cyc();
      chk("start_held_not_ready", n_start, exp_start);
      chk("no_ack_while_start", n_ans, a0);
      chk("busy_start", busy, 1);
      fft_ready = 1'b1;
      cyc();
      exp_start++;
      chk("start_on_ready", n_start, exp_start);
      chk("wr_not_after_start2", last_wr_cyc <= start_cyc, 1);
      cyc();
      chk("no_ack_wait_done", n_ans, a0);
      fft_done = 1'b1;
      cyc();
      fft_done = 1'b0;
      frames++;
      wait_ack("stalled_req_ack", a0, 16'hBEEF);
      req_i = 1'b0;
      cyc();
      chk("frame_cnt2", frame_cnt, frames % 256);
    end

    // Frame 3: enable drops after the third sample; frame still completes.
    for (int s = 1; s < 3; s++) send(DW'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    enable = 1'b0;
    for (int s = 3; s < NP; s++) send(DW'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    check_frame();
    frame_end(1'b0);
    chk("idle_after_done", busy, 0);
    fft_done = 1'b1;
    cyc();
    fft_done = 1'b0;
    cyc();
    chk("done_in_idle_ignored", frame_cnt, frames % 256);

    // Request stalled in IDLE, taken once enabled; then reset mid-frame.
    begin
      int a0;
      a0 = n_ans;
      req_i  = 1'b1;
      data_i = 16'h5A5A;
      repeat (3) cyc();
      chk("no_ack_idle", n_ans, a0);
      enable = 1'b1;
      wait_ack("idle_stall_ack", a0, 16'h5A5A);
      req_i = 1'b0;
      cyc();
    end
    for (int s = 1; s < 5; s++) send(DW'($urandom), 0, $urandom_range(0, 2));
    check_frame();
    begin
      int a0;
      req_i  = 1'b1;
      data_i = 16'hC0DE;
      rst    = 1'b1;
      a0     = n_ans;
      cyc();
      cyc();
      chk("mrst_busy", busy, 0);
      chk("mrst_ans", ans_o, 0);
      chk("mrst_wr_en", wr_en, 0);
      chk("mrst_wr_addr", wr_addr, 0);
      chk("mrst_wr_data", wr_data, 0);
      chk("mrst_frame_cnt", frame_cnt, 0);
      idx = 0;
      frames = 0;
      rst = 1'b0;
      repeat (2) cyc();
      chk("no_ack_after_rst", n_ans, a0);
      chk("no_write_after_rst", got_q.size(), 0);
      req_i = 1'b0;
      cyc();
    end

    // 256 back-to-back frames: first starts at address 0, counter wraps.
    for (int f = 0; f < 256; f++) begin
      for (int s = 0; s < NP; s++) send(DW'($urandom), 0, 0);
      check_frame();
      frame_end(1'b1);
    end
    chk("frame_cnt_wrapped", frame_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 The block SHALL have parameter N_POINTS, default 64, meaning FFT frame length (power of two, 8..1024).
REQ-002 The block SHALL have parameter DW, default 16, meaning sample width.
REQ-003 The block SHALL have parameter BITREV, default 1, meaning 1 = bit-reversed write addressing, 0 = natural order.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 enable  input  1  run request; frames are captured back to back while high.
REQ-008 req_i  input  1  source sample request, four-phase handshake.
REQ-009 data_i  input  DW  source sample, valid while req_i is high.
REQ-010 ans_o  output  1  one-cycle acknowledge to source.
REQ-011 wr_en  output  1  frame-buffer write strobe.
REQ-012 wr_addr  output  log2(N_POINTS)  frame-buffer write address.
REQ-013 wr_data  output  DW  frame-buffer write data.
REQ-014 fft_ready  input  1  FFT core idle and able to start.
REQ-015 fft_start  output  1  one-cycle FFT start pulse.
REQ-016 fft_done  input  1  one-cycle FFT completion pulse.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 frame_cnt  output  8  completed-frame counter, wraps 255 -> 0.

Function
REQ-019 The FSM SHALL have the states IDLE, CAPTURE, START and WAIT_DONE.
REQ-020 IDLE: enable=1 -> CAPTURE with sample count 0; otherwise stay.
REQ-021 CAPTURE: a sample SHALL be accepted on an edge where req_i=1, armed=1 and ans_o=0.
REQ-022 In the cycle after an accept, ans_o, wr_en, wr_data=accepted data_i and wr_addr SHALL all be high/valid for exactly one cycle (latency 1).
REQ-023 armed SHALL clear on accept and set when req_i is sampled low, so a held req_i never yields a second accept.
REQ-024 wr_addr SHALL equal the sample count, bit-reversed over log2(N_POINTS) bits when BITREV=1; the count SHALL increment per accept.
REQ-025 On accepting sample N_POINTS-1, the FSM SHALL go to START and the count SHALL wrap to 0.
REQ-026 In CAPTURE, enable falling SHALL NOT abort the frame; the frame SHALL complete.
REQ-027 START: fft_start SHALL pulse for one cycle on the first cycle with fft_ready=1, then the FSM SHALL go to WAIT_DONE; with fft_ready=0 it SHALL wait indefinitely.
REQ-028 The final wr_en SHALL precede or coincide with the fft_start cycle, never follow it.
REQ-029 WAIT_DONE: on fft_done, frame_cnt SHALL increment and the FSM SHALL go to CAPTURE if enable=1, else IDLE (fft_done and enable=0 in the same cycle -> IDLE).
REQ-030 In IDLE, START and WAIT_DONE, ans_o and wr_en SHALL be 0; req_i SHALL be stalled, not dropped, and SHALL be accepted once CAPTURE resumes.
REQ-031 fft_done outside WAIT_DONE SHALL be ignored.

Reset
REQ-032 On rst=1, the FSM SHALL go to IDLE and the count, armed, frame_cnt, ans_o, wr_en, wr_addr, wr_data and fft_start SHALL all go to 0.
REQ-033 rst in mid-frame or mid-handshake SHALL discard the partial frame; no pulse SHALL be emitted in the reset cycle or the following cycle.
REQ-034 armed SHALL stay 0 after reset until req_i is seen low.

Structure
REQ-035 The FSM state encoding and the bit-reverse function SHALL live in the shared package fft_pkg.
REQ-036 One sub-module SHALL be used: fft_handshake_rx (req/ans edge logic, armed flag, data capture), instantiated once.
REQ-037 The frame buffer SHALL be external.

Verification (N_POINTS=8, DW=16, BITREV=1)
REQ-038 Reset, then enable=1 and 8 clean handshakes with data 0x0001..0x0008 -> wr_addr sequence 0,4,2,6,1,5,3,7 with matching data; then fft_start pulses once with fft_ready=1.
REQ-039 req_i held high for 5 cycles with data 0x1234 -> exactly one ans_o/wr_en; count increments by 1.
REQ-040 fft_ready=0 for 10 cycles after the 8th sample -> fft_start occurs on the cycle fft_ready rises; req_i raised during this time -> no ans_o until after fft_done.
REQ-041 enable dropped after sample 3 -> frame completes to 8 samples; fft_done with enable=0 -> IDLE, busy=0, frame_cnt=1.
REQ-042 rst asserted after sample 5 -> all outputs 0 and IDLE; the next frame starts at wr_addr 0.
REQ-043 256 frames run -> frame_cnt wraps to 0.
